// File: rtl/imem_fetch_sequencer_if.sv
// Bus bundle between the instruction-memory fetch sequencer and its environment:
// program loader, instruction memory ports and the single-cycle datapath.
interface imem_fetch_sequencer_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  // program loader
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;

  // instruction memory
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [63:0]   imem_addr;
  logic [31:0]   imem_rdata;

  // datapath
  logic          run;
  logic          stall;
  logic          branch_taken;
  logic [63:0]   branch_target;
  logic [63:0]   pc_out;
  logic [31:0]   instr_out;
  logic          instr_valid;

  // status
  logic [AW:0]   loaded_count;
  logic [15:0]   retired_count;
  logic          halted;
  logic          fault;
  logic [63:0]   fault_pc;

  // sequencer side
  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  imem_rdata,
    input  run, stall, branch_taken, branch_target,
    output load_ready,
    output imem_we, imem_waddr, imem_wdata, imem_addr,
    output pc_out, instr_out, instr_valid,
    output loaded_count, retired_count, halted, fault, fault_pc
  );

  // environment side (loader, memory, datapath)
  modport master (
    output load_start, load_valid, load_data, load_last,
    output imem_rdata,
    output run, stall, branch_taken, branch_target,
    input  load_ready,
    input  imem_we, imem_waddr, imem_wdata, imem_addr,
    input  pc_out, instr_out, instr_valid,
    input  loaded_count, retired_count, halted, fault, fault_pc
  );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction memory fetch sequencer: loads a program through the IMEM write
// port, then steps the PC and issues instructions to a single-cycle datapath.
// LOAD and RUN are mutually exclusive, so memory is never written and fetched
// at the same time. RUN ends at a halt word, at end of program, or on a bad
// branch target (sticky fault with the offending pc captured).
module imem_fetch_sequencer #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  imem_fetch_sequencer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic [15:0]   retired_q, retired_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [63:0]   fault_pc_q, fault_pc_d;

  logic          load_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [63:0]   imem_addr;
  logic [31:0]   instr_out;
  logic          instr_valid;

  logic [63:0]   prog_end;
  logic [63:0]   pc_plus4;
  logic          target_bad;

  // Retired-instruction counter saturates rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Byte address one past the last loaded word; every legal pc lies below it.
  assign prog_end   = {{(64-AW-3){1'b0}}, loaded_q, 2'b00};
  assign pc_plus4   = pc_q + 64'd4;
  assign target_bad = (bus.branch_target[1:0] != 2'b00) ||
                      (bus.branch_target >= prog_end);

  // State and architectural registers; reset returns everything to a blank IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 64'd0;
      wptr_q     <= '0;
      loaded_q   <= '0;
      retired_q  <= 16'd0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wptr_q     <= wptr_d;
      loaded_q   <= loaded_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Next-state and output decode; memory ports are only active in their own state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wptr_d      = wptr_q;
    loaded_d    = loaded_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    imem_waddr  = '0;
    imem_wdata  = 32'd0;
    imem_addr   = 64'd0;
    instr_out   = 32'd0;
    instr_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d  = S_LOAD;
          wptr_d   = '0;
          loaded_d = '0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end else if (bus.run && (loaded_q != '0)) begin
          state_d   = S_RUN;
          pc_d      = 64'd0;
          retired_d = 16'd0;
          halted_d  = 1'b0;
          fault_d   = 1'b0;
        end
      end

      S_LOAD: begin
        load_ready = 1'b1;
        imem_we    = bus.load_valid;
        imem_waddr = wptr_q;
        imem_wdata = bus.load_data;
        if (bus.load_valid) begin
          wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
          // A full memory closes the program even without load_last.
          if (bus.load_last || (wptr_q == AW'(DEPTH - 1))) begin
            loaded_d = {1'b0, wptr_q} + {{AW{1'b0}}, 1'b1};
            state_d  = S_IDLE;
          end
        end
      end

      S_RUN: begin
        imem_addr = pc_q;
        instr_out = bus.imem_rdata;
        if (!bus.stall) begin
          if (bus.imem_rdata == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            instr_valid = 1'b1;
            retired_d   = sat_inc16(retired_q);
            if (bus.branch_taken) begin
              if (target_bad) begin
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
                state_d    = S_FAULT;
              end else begin
                pc_d = bus.branch_target;
              end
            end else if (pc_plus4 == prog_end) begin
              // Fell off the last word: stop with pc on the final instruction.
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end

      S_HALT, S_FAULT: begin
        if (bus.load_start) begin
          state_d  = S_LOAD;
          wptr_d   = '0;
          loaded_d = '0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end else if (bus.run) begin
          state_d   = S_RUN;
          pc_d      = 64'd0;
          retired_d = 16'd0;
          halted_d  = 1'b0;
          fault_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.load_ready    = load_ready;
  assign bus.imem_we       = imem_we;
  assign bus.imem_waddr    = imem_waddr;
  assign bus.imem_wdata    = imem_wdata;
  assign bus.imem_addr     = imem_addr;
  assign bus.pc_out        = pc_q;
  assign bus.instr_out     = instr_out;
  assign bus.instr_valid   = instr_valid;
  assign bus.loaded_count  = loaded_q;
  assign bus.retired_count = retired_q;
  assign bus.halted        = halted_q;
  assign bus.fault         = fault_q;
  assign bus.fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: a vector table covers load and a
// straight-line run, hand-written sequences cover halt word, branches, faults,
// stall, reset mid-load and a full-depth load.
module tb_imem_fetch_sequencer;

  localparam logic [31:0] W_A  = 32'hF2A00001;  // MOVK
  localparam logic [31:0] W_B  = 32'hF2C00002;  // MOVK
  localparam logic [31:0] W_C  = 32'h8B020020;  // ADD
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imem_fetch_sequencer_if bus ();

  imem_fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: synchronous write, asynchronous word read.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  end
  assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

  typedef struct {
    logic        ls, lv, ll, rn;
    logic [31:0] ld;
    logic        ready, we;
    logic [5:0]  waddr;
    logic [63:0] addr, pc;
    logic [31:0] instr;
    logic        iv, halted, fault;
    logic [6:0]  loaded;
    logic [15:0] retired;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = 32'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.load_start    = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_data     = 32'd0;
    bus.load_last     = 1'b0;
    bus.run           = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 64'd0;

    // ls lv ll rn ld | ready we waddr addr pc instr iv halted fault loaded retired
    tbl[0]  = '{0,0,0,0,32'd0, 0,0,6'd0,64'd0,64'd0,32'd0,0,0,0,7'd0,16'd0};
    tbl[1]  = '{1,0,0,0,32'd0, 0,0,6'd0,64'd0,64'd0,32'd0,0,0,0,7'd0,16'd0};
    tbl[2]  = '{0,1,0,0,W_A,   1,1,6'd0,64'd0,64'd0,32'd0,0,0,0,7'd0,16'd0};
    tbl[3]  = '{0,1,0,0,W_B,   1,1,6'd1,64'd0,64'd0,32'd0,0,0,0,7'd0,16'd0};
    tbl[4]  = '{0,1,1,0,W_C,   1,1,6'd2,64'd0,64'd0,32'd0,0,0,0,7'd0,16'd0};
    tbl[5]  = '{0,0,0,0,32'd0, 0,0,6'd0,64'd0,64'd0,32'd0,0,0,0,7'd3,16'd0};
    tbl[6]  = '{0,0,0,1,32'd0, 0,0,6'd0,64'd0,64'd0,32'd0,0,0,0,7'd3,16'd0};
    tbl[7]  = '{0,0,0,0,32'd0, 0,0,6'd0,64'd0,64'd0,W_A,  1,0,0,7'd3,16'd0};
    tbl[8]  = '{0,0,0,0,32'd0, 0,0,6'd0,64'd4,64'd4,W_B,  1,0,0,7'd3,16'd1};
    tbl[9]  = '{0,0,0,0,32'd0, 0,0,6'd0,64'd8,64'd8,W_C,  1,0,0,7'd3,16'd2};
    tbl[10] = '{0,0,0,0,32'd0, 0,0,6'd0,64'd0,64'd8,32'd0,0,1,0,7'd3,16'd3};

    step();
    step();
    reset = 1'b0;
    mid();
    chk("rst_fault_pc", bus.fault_pc, 64'd0);

    // Load of three words followed by a straight-line run to end of program.
    for (int i = 0; i < 11; i++) begin
      bus.load_start = tbl[i].ls;
      bus.load_valid = tbl[i].lv;
      bus.load_last  = tbl[i].ll;
      bus.run        = tbl[i].rn;
      bus.load_data  = tbl[i].ld;
      mid();
      chk($sformatf("v%0d_ready", i),   {63'd0, bus.load_ready},  {63'd0, tbl[i].ready});
      chk($sformatf("v%0d_we", i),      {63'd0, bus.imem_we},     {63'd0, tbl[i].we});
      chk($sformatf("v%0d_waddr", i),   {58'd0, bus.imem_waddr},  {58'd0, tbl[i].waddr});
      chk($sformatf("v%0d_addr", i),    bus.imem_addr,            tbl[i].addr);
      chk($sformatf("v%0d_pc", i),      bus.pc_out,               tbl[i].pc);
      chk($sformatf("v%0d_instr", i),   {32'd0, bus.instr_out},   {32'd0, tbl[i].instr});
      chk($sformatf("v%0d_iv", i),      {63'd0, bus.instr_valid}, {63'd0, tbl[i].iv});
      chk($sformatf("v%0d_halted", i),  {63'd0, bus.halted},      {63'd0, tbl[i].halted});
      chk($sformatf("v%0d_fault", i),   {63'd0, bus.fault},       {63'd0, tbl[i].fault});
      chk($sformatf("v%0d_loaded", i),  {57'd0, bus.loaded_count},{57'd0, tbl[i].loaded});
      chk($sformatf("v%0d_retired", i), {48'd0, bus.retired_count},{48'd0, tbl[i].retired});
      step();
    end
    bus.run = 1'b0;

    // Halt word in the middle of the program.
    pulse_start();
    load_word(W_A, 1'b0);
    load_word(HALT, 1'b0);
    load_word(W_C, 1'b1);
    pulse_run();
    mid();
    chk("hw_pc0_iv", {63'd0, bus.instr_valid}, 64'd1);
    chk("hw_pc0_instr", {32'd0, bus.instr_out}, {32'd0, W_A});
    step();
    mid();
    chk("hw_pc4_pc", bus.pc_out, 64'd4);
    chk("hw_pc4_iv", {63'd0, bus.instr_valid}, 64'd0);
    step();
    mid();
    chk("hw_halted", {63'd0, bus.halted}, 64'd1);
    chk("hw_pc_hold", bus.pc_out, 64'd4);
    chk("hw_retired", {48'd0, bus.retired_count}, 64'd1);

    // Branches: legal back-branch, misaligned target, out-of-range target.
    pulse_start();
    load_word(W_A, 1'b0);
    load_word(W_B, 1'b0);
    load_word(W_C, 1'b0);
    load_word(W_A, 1'b1);
    pulse_run();
    step();
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd0;
    mid();
    chk("br_pc8_iv", {63'd0, bus.instr_valid}, 64'd1);
    chk("br_pc8_pc", bus.pc_out, 64'd8);
    step();
    bus.branch_taken = 1'b0;
    mid();
    chk("br_to0_pc", bus.pc_out, 64'd0);
    step();
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd6;
    mid();
    chk("misal_iv", {63'd0, bus.instr_valid}, 64'd1);
    step();
    bus.branch_taken = 1'b0;
    mid();
    chk("misal_fault", {63'd0, bus.fault}, 64'd1);
    chk("misal_fault_pc", bus.fault_pc, 64'd8);
    chk("misal_pc_hold", bus.pc_out, 64'd8);
    chk("misal_iv_after", {63'd0, bus.instr_valid}, 64'd0);
    chk("misal_we", {63'd0, bus.imem_we}, 64'd0);
    chk("misal_retired", {48'd0, bus.retired_count}, 64'd6);
    pulse_run();
    mid();
    chk("rerun_fault_clr", {63'd0, bus.fault}, 64'd0);
    chk("rerun_retired_clr", {48'd0, bus.retired_count}, 64'd0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd12;
    step();
    bus.branch_target = 64'd16;
    mid();
    chk("br_last_pc", bus.pc_out, 64'd12);
    chk("br_last_retired", {48'd0, bus.retired_count}, 64'd1);
    step();
    bus.branch_taken = 1'b0;
    mid();
    chk("oor_fault", {63'd0, bus.fault}, 64'd1);
    chk("oor_fault_pc", bus.fault_pc, 64'd12);
    chk("oor_retired", {48'd0, bus.retired_count}, 64'd2);

    // Stall two cycles at pc 4, then resume and run to end of program.
    pulse_run();
    mid();
    chk("st_pc0_iv", {63'd0, bus.instr_valid}, 64'd1);
    step();
    bus.stall = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd6;
    mid();
    chk("st1_pc", bus.pc_out, 64'd4);
    chk("st1_iv", {63'd0, bus.instr_valid}, 64'd0);
    step();
    mid();
    chk("st2_pc", bus.pc_out, 64'd4);
    chk("st2_iv", {63'd0, bus.instr_valid}, 64'd0);
    chk("st2_retired", {48'd0, bus.retired_count}, 64'd1);
    chk("st2_fault", {63'd0, bus.fault}, 64'd0);
    step();
    bus.stall = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 64'd0;
    mid();
    chk("st_resume_iv", {63'd0, bus.instr_valid}, 64'd1);
    step();
    mid();
    chk("st_resume_pc", bus.pc_out, 64'd8);
    chk("st_resume_retired", {48'd0, bus.retired_count}, 64'd2);
    step();
    step();
    mid();
    chk("eop_halted", {63'd0, bus.halted}, 64'd1);
    chk("eop_pc", bus.pc_out, 64'd12);

    // Reset in the middle of a load discards the partial program.
    pulse_start();
    load_word(W_A, 1'b0);
    load_word(W_B, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mid();
    chk("rl_loaded", {57'd0, bus.loaded_count}, 64'd0);
    chk("rl_ready", {63'd0, bus.load_ready}, 64'd0);
    pulse_run();
    mid();
    chk("rl_run_ignored_iv", {63'd0, bus.instr_valid}, 64'd0);
    chk("rl_run_ignored_addr", bus.imem_addr, 64'd0);
    chk("rl_run_ignored_ready", {63'd0, bus.load_ready}, 64'd0);

    // Full-depth load without load_last ends automatically.
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'h1000 + i;
      mid();
      if (i == 63) begin
        chk("full_waddr63", {58'd0, bus.imem_waddr}, 64'd63);
        chk("full_we63", {63'd0, bus.imem_we}, 64'd1);
      end
      step();
    end
    bus.load_valid = 1'b0;
    mid();
    chk("full_loaded", {57'd0, bus.loaded_count}, 64'd64);
    chk("full_ready", {63'd0, bus.load_ready}, 64'd0);
    chk("full_mem63", {32'd0, mem[63]}, 64'h103F);

    // load_start and run together: load wins.
    bus.load_start = 1'b1;
    bus.run        = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.run        = 1'b0;
    mid();
    chk("both_ready", {63'd0, bus.load_ready}, 64'd1);
    chk("both_loaded", {57'd0, bus.loaded_count}, 64'd0);
    chk("both_iv", {63'd0, bus.instr_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
